// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Shares one RAM port between data, fetch and periph         |
// |               requesters. One registered RAM command per cycle, with     |
// |               fixed priority data > fetch > periph. A periph starvation  |
// |               counter promotes periph to the top once it saturates. Read |
// |               data is routed to its owner through a tagged latency pipe. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst_n              clock, asynchronous active-low reset           |
// |   data_*_i / data_*_o     MEM-stage load/store port (req/we/addr/wdata,  |
// |                           gnt, rvalid, rdata)                            |
// |   fetch_*_i / fetch_*_o   instruction read port (req/addr, gnt, rvalid,  |
// |                           rdata)                                         |
// |   periph_*_i / periph_*_o peripheral DMA port (same set as data)         |
// |   ram_*_o, ram_rdata_i    registered RAM command and read return         |
// |   pipe_stall_o            a core (data/fetch) request is waiting         |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // data requester
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [DW-1:0] data_rdata_o,
  // fetch requester (read only)
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [DW-1:0] fetch_rdata_o,
  // periph requester
  input  logic          periph_req_i,
  input  logic          periph_we_i,
  input  logic [AW-1:0] periph_addr_i,
  input  logic [DW-1:0] periph_wdata_i,
  output logic          periph_gnt_o,
  output logic          periph_rvalid_o,
  output logic [DW-1:0] periph_rdata_o,
  // RAM port
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  // pipeline hold
  output logic          pipe_stall_o
);

  localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_DATA   = 2'd1,
    OWN_FETCH  = 2'd2,
    OWN_PERIPH = 2'd3
  } owner_e;

  logic [SW-1:0] starve_q, starve_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  owner_e        tag_d;
  owner_e        tag_q [RD_LAT];
  logic          data_rvalid_q, fetch_rvalid_q, periph_rvalid_q;
  logic [DW-1:0] data_hold_q, fetch_hold_q, periph_hold_q;
  logic          periph_forced;

  assign periph_forced = (starve_q == STARVE_MAX);

  // Arbitration. Grants are combinational and forced low while in reset.
  always_comb begin
    data_gnt_o   = 1'b0;
    fetch_gnt_o  = 1'b0;
    periph_gnt_o = 1'b0;
    if (rst_n) begin
      if (periph_req_i && periph_forced) begin
        periph_gnt_o = 1'b1;
      end else if (data_req_i) begin
        data_gnt_o = 1'b1;
      end else if (fetch_req_i) begin
        fetch_gnt_o = 1'b1;
      end else if (periph_req_i) begin
        periph_gnt_o = 1'b1;
      end
    end
  end

  // Winner's command for the next cycle. addr/wdata keep their last value
  // when nothing is granted; fetch has no write data, so wdata holds on a
  // fetch grant. Only reads carry an owner tag into the return pipe.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag_d       = OWN_NONE;
    if (data_gnt_o) begin
      ram_en_d    = 1'b1;
      ram_we_d    = data_we_i;
      ram_addr_d  = data_addr_i;
      ram_wdata_d = data_wdata_i;
      tag_d       = data_we_i ? OWN_NONE : OWN_DATA;
    end else if (fetch_gnt_o) begin
      ram_en_d    = 1'b1;
      ram_addr_d  = fetch_addr_i;
      tag_d       = OWN_FETCH;
    end else if (periph_gnt_o) begin
      ram_en_d    = 1'b1;
      ram_we_d    = periph_we_i;
      ram_addr_d  = periph_addr_i;
      ram_wdata_d = periph_wdata_i;
      tag_d       = periph_we_i ? OWN_NONE : OWN_PERIPH;
    end
  end

  // Starvation counter: counts cycles periph waits, saturates, clears on grant.
  always_comb begin
    starve_d = starve_q;
    if (periph_gnt_o) begin
      starve_d = '0;
    end else if (periph_req_i && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Owner tag pipe. Stage 0 is loaded alongside ram_en, so the last stage
  // lines up with the cycle before ram_rdata is valid; the rvalid register
  // behind it then asserts exactly in the cycle the RAM presents the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= OWN_NONE;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Return: rvalid is registered from the tag pipe. During the rvalid cycle
  // the owner's rdata shows ram_rdata directly and is captured into a hold
  // register at the end of that cycle, so every rdata holds between returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_rvalid_q   <= 1'b0;
      fetch_rvalid_q  <= 1'b0;
      periph_rvalid_q <= 1'b0;
      data_hold_q     <= '0;
      fetch_hold_q    <= '0;
      periph_hold_q   <= '0;
    end else begin
      data_rvalid_q   <= (tag_q[RD_LAT-1] == OWN_DATA);
      fetch_rvalid_q  <= (tag_q[RD_LAT-1] == OWN_FETCH);
      periph_rvalid_q <= (tag_q[RD_LAT-1] == OWN_PERIPH);
      if (data_rvalid_q) begin
        data_hold_q <= ram_rdata_i;
      end
      if (fetch_rvalid_q) begin
        fetch_hold_q <= ram_rdata_i;
      end
      if (periph_rvalid_q) begin
        periph_hold_q <= ram_rdata_i;
      end
    end
  end

  assign data_rvalid_o   = data_rvalid_q;
  assign fetch_rvalid_o  = fetch_rvalid_q;
  assign periph_rvalid_o = periph_rvalid_q;
  assign data_rdata_o    = data_rvalid_q   ? ram_rdata_i : data_hold_q;
  assign fetch_rdata_o   = fetch_rvalid_q  ? ram_rdata_i : fetch_hold_q;
  assign periph_rdata_o  = periph_rvalid_q ? ram_rdata_i : periph_hold_q;

  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

  assign pipe_stall_o = (data_req_i & ~data_gnt_o) | (fetch_req_i & ~fetch_gnt_o);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                        |
// | Description : Two arbiters (RD_LAT=1 and RD_LAT=3) driven by the same    |
// |               requesters. Each has its own RAM model and a monitor that  |
// |               predicts grants, RAM commands and read returns from the    |
// |               arbitration rules and a shadow memory, with a queue of     |
// |               outstanding reads popped whenever an rvalid appears.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  req;            // [0]=data [1]=fetch [2]=periph
  logic        data_we, periph_we;
  logic [15:0] data_addr, data_wdata, fetch_addr, periph_addr, periph_wdata;

  logic [1:0][2:0]       gnt_v, rvalid_v;
  logic [1:0][2:0][15:0] rdata_v;
  logic [1:0]            ram_en_v, ram_we_v, stall_v;
  logic [1:0][15:0]      ram_addr_v, ram_wdata_v, ram_rdata_v;

  int         checks = 0;
  int         errors = 0;
  int         pend [2];
  logic [2:0] last_g;

  typedef struct {
    logic [2:0]  own;
    logic [15:0] dat;
    int          due;
  } rd_t;

  function automatic logic [15:0] init_val(input int a);
    if (a == 16) return 16'hBEEF;
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  task automatic chk(input int inst, input string nm, input bit ok,
                     input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL i%0d %s actual=0x%0h required=0x%0h", inst, nm, act, exp_v);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int LAT = (k == 0) ? 1 : 3;

    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(LAT), .STARVE_LIMIT(LIMIT)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_req_i     (req[0]),
      .data_we_i      (data_we),
      .data_addr_i    (data_addr),
      .data_wdata_i   (data_wdata),
      .data_gnt_o     (gnt_v[k][0]),
      .data_rvalid_o  (rvalid_v[k][0]),
      .data_rdata_o   (rdata_v[k][0]),
      .fetch_req_i    (req[1]),
      .fetch_addr_i   (fetch_addr),
      .fetch_gnt_o    (gnt_v[k][1]),
      .fetch_rvalid_o (rvalid_v[k][1]),
      .fetch_rdata_o  (rdata_v[k][1]),
      .periph_req_i   (req[2]),
      .periph_we_i    (periph_we),
      .periph_addr_i  (periph_addr),
      .periph_wdata_i (periph_wdata),
      .periph_gnt_o   (gnt_v[k][2]),
      .periph_rvalid_o(rvalid_v[k][2]),
      .periph_rdata_o (rdata_v[k][2]),
      .ram_en_o       (ram_en_v[k]),
      .ram_we_o       (ram_we_v[k]),
      .ram_addr_o     (ram_addr_v[k]),
      .ram_wdata_o    (ram_wdata_v[k]),
      .ram_rdata_i    (ram_rdata_v[k]),
      .pipe_stall_o   (stall_v[k])
    );

    // RAM: 64 words, read data appears LAT cycles after the ram_en cycle.
    logic [15:0] mem   [64];
    logic [15:0] rpipe [LAT];
    initial begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end
    always @(posedge clk) begin
      if (ram_en_v[k] && ram_we_v[k]) mem[ram_addr_v[k][5:0]] <= ram_wdata_v[k];
      rpipe[0] <= mem[ram_addr_v[k][5:0]];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata_v[k] = rpipe[LAT-1];

    // Reference model and monitor.
    initial begin : p_mon
      rd_t         q[$];
      rd_t         e;
      logic [15:0] shadow [64];
      logic [15:0] held [3];
      int          starve, cyc;
      logic        exp_en, exp_we;
      logic [15:0] exp_addr, exp_wdata;
      logic [2:0]  rq, w, own;
      for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
      for (int o = 0; o < 3; o++) held[o] = '0;
      starve = 0; cyc = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
      pend[k] = 0;
      forever begin
        @(negedge clk);
        cyc++;
        rq = req;
        if (!rst_n) begin
          chk(k, "reset gnt", gnt_v[k] == 3'b000, gnt_v[k], 0);
          chk(k, "reset ram_en", ram_en_v[k] == 1'b0, ram_en_v[k], 0);
          chk(k, "reset ram_we", ram_we_v[k] == 1'b0, ram_we_v[k], 0);
          chk(k, "reset ram_addr", ram_addr_v[k] == 16'h0, ram_addr_v[k], 0);
          chk(k, "reset ram_wdata", ram_wdata_v[k] == 16'h0, ram_wdata_v[k], 0);
          chk(k, "reset rvalid", rvalid_v[k] == 3'b000, rvalid_v[k], 0);
          for (int o = 0; o < 3; o++)
            chk(k, "reset rdata", rdata_v[k][o] == 16'h0, rdata_v[k][o], 0);
          chk(k, "reset stall", stall_v[k] == (rq[0] | rq[1]), stall_v[k], rq[0] | rq[1]);
          q.delete();
          for (int o = 0; o < 3; o++) held[o] = '0;
          starve = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
        end else begin
          chk(k, "ram_en", ram_en_v[k] == exp_en, ram_en_v[k], exp_en);
          chk(k, "ram_we", ram_we_v[k] == exp_we, ram_we_v[k], exp_we);
          chk(k, "ram_addr", ram_addr_v[k] == exp_addr, ram_addr_v[k], exp_addr);
          chk(k, "ram_wdata", ram_wdata_v[k] == exp_wdata, ram_wdata_v[k], exp_wdata);

          // Read returns: any rvalid, or a head entry that is due, is scored.
          if (rvalid_v[k] != 3'b000 || (q.size() > 0 && q[0].due <= cyc)) begin
            own = (q.size() > 0) ? q[0].own : 3'b000;
            chk(k, "rvalid present", rvalid_v[k] != 3'b000 && q.size() > 0, rvalid_v[k], own);
            if (q.size() > 0) begin
              e = q.pop_front();
              chk(k, "rvalid owner", rvalid_v[k] == e.own, rvalid_v[k], e.own);
              chk(k, "rvalid cycle", cyc == e.due, cyc, e.due);
              for (int o = 0; o < 3; o++) if (e.own[o]) held[o] = e.dat;
            end
          end
          for (int o = 0; o < 3; o++)
            chk(k, "rdata", rdata_v[k][o] == held[o], rdata_v[k][o], held[o]);

          // Arbitration rules.
          if (rq[2] && starve == LIMIT) w = 3'b100;
          else if (rq[0])               w = 3'b001;
          else if (rq[1])               w = 3'b010;
          else if (rq[2])               w = 3'b100;
          else                          w = 3'b000;
          chk(k, "gnt", gnt_v[k] == w, gnt_v[k], w);
          chk(k, "pipe_stall", stall_v[k] == ((rq[0] & ~w[0]) | (rq[1] & ~w[1])),
              stall_v[k], (rq[0] & ~w[0]) | (rq[1] & ~w[1]));

          if (w[2])      starve = 0;
          else if (rq[2]) starve = (starve < LIMIT) ? starve + 1 : LIMIT;

          exp_en = (w != 3'b000);
          exp_we = (w[0] & data_we) | (w[2] & periph_we);
          if (w[0]) begin
            exp_addr = data_addr; exp_wdata = data_wdata;
            if (data_we) shadow[data_addr[5:0]] = data_wdata;
            else q.push_back('{3'b001, shadow[data_addr[5:0]], cyc + 1 + LAT});
          end else if (w[1]) begin
            exp_addr = fetch_addr;
            q.push_back('{3'b010, shadow[fetch_addr[5:0]], cyc + 1 + LAT});
          end else if (w[2]) begin
            exp_addr = periph_addr; exp_wdata = periph_wdata;
            if (periph_we) shadow[periph_addr[5:0]] = periph_wdata;
            else q.push_back('{3'b100, shadow[periph_addr[5:0]], cyc + 1 + LAT});
          end
        end
        pend[k] = q.size();
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge and
  // outputs are sampled at the falling edge. A granted request drops.
  task automatic to_drive();
    @(posedge clk);
    #1;
    req = req & ~last_g;
  endtask

  task automatic to_neg();
    @(negedge clk);
    last_g = gnt_v[0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      to_drive();
      to_neg();
    end
  endtask

  task automatic raise(input int o);
    case (o)
      0: begin
        data_we    = 1'($urandom_range(0, 1));
        data_addr  = {10'd0, 6'($urandom)};
        data_wdata = 16'($urandom);
      end
      1: fetch_addr = {10'd0, 6'($urandom)};
      default: begin
        periph_we    = 1'($urandom_range(0, 1));
        periph_addr  = {10'd0, 6'($urandom)};
        periph_wdata = 16'($urandom);
      end
    endcase
    req[o] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req = 3'b000; last_g = 3'b000;
    data_we = 0; data_addr = 0; data_wdata = 0; fetch_addr = 0;
    periph_we = 0; periph_addr = 0; periph_wdata = 0;
    idle(3);
    to_drive(); rst_n = 1'b1;
    to_neg();
    idle(2);

    // Reset while a data read is in flight.
    to_drive(); req[0] = 1'b1; data_we = 1'b0; data_addr = 16'h0005;
    to_neg();   chk(0, "t1 gnt", gnt_v[0] == 3'b001, gnt_v[0], 3'b001);
    to_drive(); rst_n = 1'b0; req = 3'b011;
    to_neg();   chk(0, "t1 gnt in reset", gnt_v == '0, gnt_v, 0);
    chk(1, "t1 ram_en in reset", ram_en_v == 2'b00, ram_en_v, 0);
    idle(1);
    to_drive(); rst_n = 1'b1; req = 3'b000;
    to_neg();
    idle(6);

    // All three request together.
    to_drive(); req = 3'b111; data_addr = 16'h0004; fetch_addr = 16'h0005;
    periph_we = 1'b0; periph_addr = 16'h0006;
    to_neg();   chk(0, "t2 gnt t",   gnt_v[0] == 3'b001, gnt_v[0], 3'b001);
    chk(0, "t2 stall t", stall_v[0] == 1'b1, stall_v[0], 1);
    to_drive(); to_neg();
    chk(0, "t2 gnt t+1", gnt_v[0] == 3'b010, gnt_v[0], 3'b010);
    chk(0, "t2 stall t+1", stall_v[0] == 1'b0, stall_v[0], 0);
    to_drive(); to_neg();
    chk(0, "t2 gnt t+2", gnt_v[0] == 3'b100, gnt_v[0], 3'b100);
    chk(0, "t2 stall t+2", stall_v[0] == 1'b0, stall_v[0], 0);
    idle(6);

    // Fetch read of 0x0010 holding 0xBEEF, RD_LAT=1 instance.
    to_drive(); req[1] = 1'b1; fetch_addr = 16'h0010;
    to_neg();   chk(0, "t3 gnt", gnt_v[0] == 3'b010, gnt_v[0], 3'b010);
    to_drive(); to_neg();
    chk(0, "t3 ram_en", ram_en_v[0] == 1'b1, ram_en_v[0], 1);
    chk(0, "t3 ram_addr", ram_addr_v[0] == 16'h0010, ram_addr_v[0], 16'h0010);
    to_drive(); to_neg();
    chk(0, "t3 rvalid", rvalid_v[0] == 3'b010, rvalid_v[0], 3'b010);
    chk(0, "t3 rdata", rdata_v[0][1] == 16'hBEEF, rdata_v[0][1], 16'hBEEF);
    idle(6);

    // Data write then fetch read of the same address, back to back.
    to_drive(); req = 3'b011; data_we = 1'b1; data_addr = 16'h0020;
    data_wdata = 16'h1234; fetch_addr = 16'h0020;
    to_neg();   chk(0, "t5 gnt t", gnt_v[0] == 3'b001, gnt_v[0], 3'b001);
    to_drive(); to_neg();
    chk(0, "t5 ram_we write", ram_we_v[0] == 1'b1, ram_we_v[0], 1);
    chk(0, "t5 ram_wdata", ram_wdata_v[0] == 16'h1234, ram_wdata_v[0], 16'h1234);
    to_drive(); data_we = 1'b0;
    to_neg();
    chk(0, "t5 ram_we read", ram_we_v[0] == 1'b0, ram_we_v[0], 0);
    chk(0, "t5 ram_en read", ram_en_v[0] == 1'b1, ram_en_v[0], 1);
    to_drive(); to_neg();
    chk(0, "t5 rvalid", rvalid_v[0] == 3'b010, rvalid_v[0], 3'b010);
    chk(0, "t5 rdata", rdata_v[0][1] == 16'h1234, rdata_v[0][1], 16'h1234);
    idle(6);

    // Interleaved reads data, periph, fetch on the RD_LAT=3 instance.
    to_drive(); req = 3'b101; data_we = 1'b0; data_addr = 16'h0001;
    periph_we = 1'b0; periph_addr = 16'h0002;
    to_neg();
    to_drive(); to_neg();
    to_drive(); req[1] = 1'b1; fetch_addr = 16'h0003;
    to_neg();
    idle(1);
    to_drive(); to_neg();
    chk(1, "t6 rvalid 1st", rvalid_v[1] == 3'b001, rvalid_v[1], 3'b001);
    chk(1, "t6 rdata data", rdata_v[1][0] == init_val(1), rdata_v[1][0], init_val(1));
    to_drive(); to_neg();
    chk(1, "t6 rvalid 2nd", rvalid_v[1] == 3'b100, rvalid_v[1], 3'b100);
    chk(1, "t6 rdata periph", rdata_v[1][2] == init_val(2), rdata_v[1][2], init_val(2));
    to_drive(); to_neg();
    chk(1, "t6 rvalid 3rd", rvalid_v[1] == 3'b010, rvalid_v[1], 3'b010);
    chk(1, "t6 rdata fetch", rdata_v[1][1] == init_val(3), rdata_v[1][1], init_val(3));
    idle(4);

    // Periph held while data and fetch alternate: wins on the 5th cycle.
    for (int c = 1; c <= 5; c++) begin
      to_drive();
      req = {1'b1, (c % 2 == 0), (c % 2 == 1)};
      to_neg();
      chk(0, "t4 gnt", gnt_v[0] == ((c == 5) ? 3'b100 : (c % 2 == 1) ? 3'b001 : 3'b010),
          gnt_v[0], (c == 5) ? 3'b100 : (c % 2 == 1) ? 3'b001 : 3'b010);
    end
    to_drive(); req = 3'b000;
    to_neg();
    idle(6);

    // Random traffic: light load, then heavy core load to exercise starvation.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        to_drive();
        for (int o = 0; o < 3; o++) begin
          if (!req[o]) begin
            if ($urandom_range(0, 99) < ((ph == 0 || o == 2) ? 35 : 85)) raise(o);
          end else if ($urandom_range(0, 99) < 3) begin
            req[o] = 1'b0;
          end
        end
        to_neg();
      end
    end
    to_drive(); req = 3'b000;
    to_neg();
    idle(10);
    for (int k = 0; k < 2; k++) chk(k, "reads outstanding", pend[k] == 0, pend[k], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
